// File: rtl/exp_frame_accum_if.sv
// Stream bundle between the exponential pipeline, the frame accumulator and
// the consumer of frame totals.
interface exp_frame_accum_if #(
   parameter int WIDTHIN = 32,
   parameter int ACCW    = 40
);
   logic               i_valid;
   logic [WIDTHIN-1:0] i_y;
   logic               o_ready;
   logic               o_valid;
   logic               i_ready;
   logic [ACCW-1:0]    o_sum;
   logic               o_ovf;

   modport master (
      output i_valid, i_y, i_ready,
      input  o_ready, o_valid, o_sum, o_ovf
   );

   modport slave (
      input  i_valid, i_y, i_ready,
      output o_ready, o_valid, o_sum, o_ovf
   );
endinterface

// File: rtl/exp_frame_accum.sv
// Buffers Q7.25 samples in a small FIFO and sums FRAME_LEN of them into a
// Q15.25 frame total presented on a registered valid/ready output.
module exp_frame_accum #(
   parameter int WIDTHIN    = 32,
   parameter int ACCW       = 40,
   parameter int FRAME_LEN  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   exp_frame_accum_if.slave bus
);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int FCNT_W = $clog2(FRAME_LEN + 1);

   typedef enum logic {ACCUM, HOLD} state_t;

   logic [WIDTHIN-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               full, empty, push, pop;

   state_t             state;
   logic [ACCW-1:0]    acc;
   logic [FCNT_W-1:0]  cnt;
   logic               ovf;
   logic               valid_q, ovf_q;
   logic [ACCW-1:0]    sum_q;

   logic [WIDTHIN-1:0] head;
   logic [ACCW:0]      sum_ext;
   logic               ovf_next, last;

   // Backpressure comes from registered occupancy only, never from i_valid.
   assign full  = (count == CNT_W'(FIFO_DEPTH));
   assign empty = (count == '0);
   assign push  = bus.i_valid & ~full & ~reset;
   assign pop   = (state == ACCUM) & ~empty;

   assign head     = mem[rd_ptr];
   assign sum_ext  = {1'b0, acc} + (ACCW+1)'(head);
   assign ovf_next = ovf | sum_ext[ACCW];
   assign last     = (cnt == FCNT_W'(FRAME_LEN - 1));

   assign bus.o_ready = ~full;
   assign bus.o_valid = valid_q;
   assign bus.o_sum   = sum_q;
   assign bus.o_ovf   = ovf_q;

   // NOTE: storage has no reset; occupancy and pointers alone define which
   // entries are live, so clearing the array would only add reset fan-out.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.i_y;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: every register below uses <= so all updates see pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ACCUM;
         acc     <= '0;
         cnt     <= '0;
         ovf     <= 1'b0;
         valid_q <= 1'b0;
         sum_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (pop) begin
                  acc <= sum_ext[ACCW-1:0];
                  ovf <= ovf_next;
                  cnt <= cnt + FCNT_W'(1);
                  if (last) begin
                     sum_q   <= sum_ext[ACCW-1:0];
                     ovf_q   <= ovf_next;
                     valid_q <= 1'b1;
                     state   <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (bus.i_ready) begin
                  valid_q <= 1'b0;
                  acc     <= '0;
                  cnt     <= '0;
                  ovf     <= 1'b0;
                  state   <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end
endmodule
